hamming_rx_ctrl: RTL and testbench

- Receive-side sequencer for the Hamming decoder datapath.
- Deserializes a bit-serial codeword of configurable length (8, 16 or 32 bits) and launches the decoder with a start/done handshake.
- Supervises decoder completion with a timeout and presents decoded data downstream on a valid/ready handshake.
- Keeps saturating corrected/uncorrectable event counters for status.

---
 rtl/hamming_rx_ctrl_if.sv | 39 +++
 rtl/hamming_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hamming_rx_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_rx_ctrl_if.sv
// Bus bundle for the Hamming receive sequencer.
// Groups the serial input stream, the decoder start/done handshake, the
// downstream valid/ready data port and the status outputs.
//   slave  : the controller side (hamming_rx_ctrl).
//   master : the environment side (bit source, decoder, consumer, status).
interface hamming_rx_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [1:0]              cfg_width;
  logic                    data_in;
  logic                    in_valid;
  logic                    in_ready;
  logic                    dec_start;
  logic [DATA_WIDTH-1:0]   dec_codeword;
  logic [1:0]              dec_len;
  logic                    dec_done;
  logic [DATA_WIDTH/2-1:0] dec_data;
  logic [1:0]              dec_err;
  logic [DATA_WIDTH/2-1:0] data_out;
  logic                    valid;
  logic                    out_ready;
  logic                    cfg_err;
  logic                    timeout;
  logic [CNT_WIDTH-1:0]    corr_cnt;
  logic [CNT_WIDTH-1:0]    unc_cnt;

  modport slave (
    input  cfg_width, data_in, in_valid, dec_done, dec_data, dec_err, out_ready,
    output in_ready, dec_start, dec_codeword, dec_len, data_out, valid,
           cfg_err, timeout, corr_cnt, unc_cnt
  );

  modport master (
    output cfg_width, data_in, in_valid, dec_done, dec_data, dec_err, out_ready,
    input  in_ready, dec_start, dec_codeword, dec_len, data_out, valid,
           cfg_err, timeout, corr_cnt, unc_cnt
  );
endinterface

// File: rtl/hamming_rx_ctrl.sv
// Receive-side sequencer for the Hamming decoder datapath.
// Deserializes an MSB-first codeword of 8/16/32 bits, launches the decoder
// with a one-cycle dec_start, supervises dec_done with a timeout, and hands
// the decoded word downstream on valid/ready. Keeps saturating counters of
// corrected and uncorrectable frames.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - hamming_rx_ctrl_if.slave: serial input (cfg_width, data_in,
//          in_valid, in_ready), decoder handshake (dec_start, dec_codeword,
//          dec_len, dec_done, dec_data, dec_err), output (data_out, valid,
//          out_ready) and status (cfg_err, timeout, corr_cnt, unc_cnt).
module hamming_rx_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEC_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  hamming_rx_ctrl_if.slave bus
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam int TW  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LAUNCH,
    S_WAIT,
    S_OUTPUT
  } state_e;

  state_e                  state_q, state_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]          frame_len;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   codeword_q, codeword_d;
  logic [1:0]              len_q, len_d;
  logic [DATA_WIDTH/2-1:0] data_q, data_d;
  logic                    start_q, start_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]    corr_q, corr_d;
  logic [CNT_WIDTH-1:0]    unc_q, unc_d;
  logic                    ready_c;
  logic                    xfer;

  always_comb begin
    case (len_q)
      2'd0:    frame_len = BCW'(8);
      2'd1:    frame_len = BCW'(16);
      default: frame_len = BCW'(32);
    endcase
  end

  assign ready_c = ((state_q == S_IDLE) && (bus.cfg_width != 2'd3)) ||
                   (state_q == S_SHIFT);
  assign xfer    = ready_c && bus.in_valid;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    codeword_d = codeword_q;
    len_d      = len_q;
    data_d     = data_q;
    start_d    = 1'b0;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    corr_d     = corr_q;
    unc_d      = unc_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          len_d      = bus.cfg_width;
          codeword_d = DATA_WIDTH'(bus.data_in);
          bit_cnt_d  = BCW'(1);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (xfer) begin
          codeword_d = {codeword_q[DATA_WIDTH-2:0], bus.data_in};
          bit_cnt_d  = bit_cnt_q + BCW'(1);
          if (bit_cnt_d == frame_len) begin
            state_d = S_LAUNCH;
            start_d = 1'b1;
            timer_d = '0;
          end
        end
      end
      S_LAUNCH: begin
        // timer tracks cycles since dec_start, so it is 1 on the first WAIT cycle
        state_d = S_WAIT;
        timer_d = TW'(1);
      end
      S_WAIT: begin
        if (bus.dec_done) begin
          if (bus.dec_err[1]) begin
            if (unc_q != '1) unc_d = unc_q + CNT_WIDTH'(1);
            state_d = S_IDLE;
          end else begin
            if (bus.dec_err[0] && (corr_q != '1)) corr_d = corr_q + CNT_WIDTH'(1);
            data_d  = bus.dec_data;
            valid_d = 1'b1;
            state_d = S_OUTPUT;
          end
        end else if (timer_q + TW'(1) == TW'(DEC_TIMEOUT)) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      codeword_q <= '0;
      len_q      <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      corr_q     <= '0;
      unc_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      codeword_q <= codeword_d;
      len_q      <= len_d;
      data_q     <= data_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      corr_q     <= corr_d;
      unc_q      <= unc_d;
    end
  end

  // IDLE-derived outputs are forced low while reset is held
  assign bus.in_ready     = ready_c && !rst;
  assign bus.cfg_err      = (state_q == S_IDLE) && (bus.cfg_width == 2'd3) && !rst;
  assign bus.dec_start    = start_q;
  assign bus.dec_codeword = codeword_q;
  assign bus.dec_len      = len_q;
  assign bus.data_out     = data_q;
  assign bus.valid        = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.corr_cnt     = corr_q;
  assign bus.unc_cnt      = unc_q;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Directed testbench for hamming_rx_ctrl: drives inputs and samples outputs
// on the falling clock edge, with hand-computed expected values.
module tb_hamming_rx_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_corr;
  int   exp_unc;

  always #5 clk = ~clk;

  hamming_rx_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

  hamming_rx_ctrl #(
    .DATA_WIDTH (32),
    .DEC_TIMEOUT(16),
    .CNT_WIDTH  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_in_ready"}, bus.in_ready, 0);
    check({pfx, "_dec_start"}, bus.dec_start, 0);
    check({pfx, "_valid"}, bus.valid, 0);
    check({pfx, "_timeout"}, bus.timeout, 0);
    check({pfx, "_cfg_err"}, bus.cfg_err, 0);
    check({pfx, "_codeword"}, bus.dec_codeword, 0);
    check({pfx, "_dec_len"}, bus.dec_len, 0);
    check({pfx, "_data_out"}, bus.data_out, 0);
    check({pfx, "_corr_cnt"}, bus.corr_cnt, 0);
    check({pfx, "_unc_cnt"}, bus.unc_cnt, 0);
  endtask

  // Sends word[n-1:0] MSB first; returns on the falling edge after the last
  // transfer with in_valid low.
  task automatic send_bits(input logic [31:0] word, input int unsigned n, input bit gaps);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.data_in  = word[n-1-k];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = 1'b0;
  endtask

  task automatic do_frame(input logic [1:0] cfg, input logic [31:0] word, input int unsigned n,
                          input bit gaps, input logic [15:0] ddata, input logic [1:0] derr,
                          input int unsigned stall, input bit chk);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    bus.cfg_width = cfg;
    send_bits(word, n, gaps);
    if (chk) begin
      check("launch_dec_start", bus.dec_start, 1);
      check("launch_in_ready", bus.in_ready, 0);
      check("launch_codeword", bus.dec_codeword, {32'd0, word} & mask);
      check("launch_dec_len", bus.dec_len, cfg);
    end
    @(negedge clk);
    if (chk) check("wait_dec_start", bus.dec_start, 0);
    @(negedge clk);
    bus.dec_done = 1'b1;
    bus.dec_data = ddata;
    bus.dec_err  = derr;
    @(negedge clk);
    bus.dec_done = 1'b0;
    if (derr[1]) begin
      if (exp_unc != 255) exp_unc++;
      if (chk) begin
        check("unc_valid", bus.valid, 0);
        check("unc_in_ready", bus.in_ready, 1);
      end
    end else begin
      if (derr[0] && (exp_corr != 255)) exp_corr++;
      for (int unsigned s = 0; s < stall; s++) begin
        if (chk) begin
          check("stall_valid", bus.valid, 1);
          check("stall_data", bus.data_out, ddata);
        end
        @(negedge clk);
      end
      bus.out_ready = 1'b1;
      if (chk) begin
        check("hs_valid", bus.valid, 1);
        check("hs_data", bus.data_out, ddata);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (chk) begin
        check("post_valid", bus.valid, 0);
        check("post_in_ready", bus.in_ready, 1);
      end
    end
    check("corr_cnt", bus.corr_cnt, exp_corr);
    check("unc_cnt", bus.unc_cnt, exp_unc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_width = 2'd0;
    bus.data_in   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dec_done  = 1'b0;
    bus.dec_data  = '0;
    bus.dec_err   = 2'b00;
    bus.out_ready = 1'b0;
    exp_corr      = 0;
    exp_unc       = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Basic 8-bit, clean; 32-bit with gaps, corrected, output stall
    do_frame(2'd0, 32'h000000B4, 8, 1'b0, 16'h000B, 2'b00, 0, 1'b1);
    do_frame(2'd2, 32'hDEADBEEF, 32, 1'b1, 16'hBEEF, 2'b01, 5, 1'b1);
    // Uncorrectable (10 and 11) with a normal frame between
    do_frame(2'd1, 32'h0000A5C3, 16, 1'b0, 16'h00A5, 2'b10, 0, 1'b1);
    do_frame(2'd1, 32'h00001234, 16, 1'b1, 16'h0012, 2'b00, 1, 1'b1);
    do_frame(2'd0, 32'h0000003C, 8, 1'b0, 16'h0003, 2'b11, 0, 1'b1);

    // Decoder never answers
    bus.cfg_width = 2'd0;
    send_bits(32'h0000005A, 8, 1'b0);
    check("to_dec_start", bus.dec_start, 1);
    for (int unsigned k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("to_pulse", bus.timeout, (k == 16));
    end
    check("to_in_ready", bus.in_ready, 1);
    bus.dec_done = 1'b1;
    bus.dec_data = 16'hFFFF;
    bus.dec_err  = 2'b01;
    @(negedge clk);
    bus.dec_done = 1'b0;
    check("late_done_valid", bus.valid, 0);
    check("late_done_corr", bus.corr_cnt, exp_corr);
    check("late_done_unc", bus.unc_cnt, exp_unc);
    @(negedge clk);
    check("late_done_valid2", bus.valid, 0);

    // Illegal width: nothing accepted
    bus.cfg_width = 2'd3;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cfg3_err", bus.cfg_err, 1);
      check("cfg3_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.data_in  = 1'b1;
    end
    @(negedge clk);
    check("cfg3_dec_start", bus.dec_start, 0);
    bus.in_valid  = 1'b0;
    bus.cfg_width = 2'd0;
    #1;
    check("cfg0_err", bus.cfg_err, 0);
    check("cfg0_in_ready", bus.in_ready, 1);
    do_frame(2'd0, 32'h00000096, 8, 1'b0, 16'h0009, 2'b00, 0, 1'b1);

    // Reset mid-frame
    bus.cfg_width = 2'd1;
    send_bits(32'h0000001F, 5, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("rst_shift");
    exp_corr = 0;
    exp_unc  = 0;
    @(negedge clk);
    rst = 1'b0;
    do_frame(2'd1, 32'h0000C0DE, 16, 1'b0, 16'h00C0, 2'b00, 0, 1'b1);

    // Reset while presenting output
    bus.cfg_width = 2'd0;
    send_bits(32'h00000081, 8, 1'b0);
    repeat (2) @(negedge clk);
    bus.dec_done = 1'b1;
    bus.dec_data = 16'h0081;
    bus.dec_err  = 2'b01;
    @(negedge clk);
    bus.dec_done = 1'b0;
    check("out_valid_before_rst", bus.valid, 1);
    check("out_corr_before_rst", bus.corr_cnt, 1);
    rst = 1'b1;
    #1;
    check_zero("rst_output");
    @(negedge clk);
    rst = 1'b0;
    do_frame(2'd0, 32'h00000042, 8, 1'b0, 16'h0004, 2'b00, 2, 1'b1);

    // Saturation of corr_cnt
    for (int unsigned f = 0; f < 256; f++) begin
      do_frame(2'd0, 32'h000000A5, 8, 1'b0, 16'h000A, 2'b01, 0, (f == 0));
    end
    check("corr_sat", bus.corr_cnt, 255);
    check("unc_after_sat", bus.unc_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
